// File: rtl/decode_control_unit.sv
// Registered, handshaked instruction decoder.
// Accepts one instruction per instr_valid/instr_ready transfer and issues
// registered control strobes and fields to the ALU, register file, data
// memory, operand mux and PC. Adds memory-operand wait sequencing, carry-
// conditional jumps on a latched carry flag, a post-jump bubble and HALT.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   instr_valid/ready   fetch handshake; instruction opcode in [3:0]
//   carry_out/valid     ALU carry result and its qualifier
//   ALU_opcode          ALU operation (all-ones = pass-through)
//   RF_addr, RF_we      register file address / write strobe
//   MEM_addr, MEM_we    data memory address / write strobe
//   IMM_value           immediate operand
//   selector            operand source: 00 RF, 01 MEM, 10 IMM, 11 RF
//   A_we                accumulator write strobe
//   PC_jump_enable/value jump strobe and target
//   halted              decoder is in HALT
module decode_control_unit #(
  parameter int unsigned INSTRUCTION_WIDTH        = 16,
  parameter int unsigned ALU_OPCODE_WIDTH         = 3,
  parameter int unsigned RF_ADDR_WIDTH            = 2,
  parameter int unsigned MEMORY_ADDR_WIDTH        = 10,
  parameter int unsigned IMMEDIATE_WIDTH          = 8,
  parameter int unsigned MUX_DEMUX_SELECTOR_WIDTH = 2,
  parameter int unsigned PC_VALUE_WIDTH           = 8,
  parameter int unsigned MEM_LATENCY              = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                instr_valid,
  output logic                                instr_ready,
  input  logic [INSTRUCTION_WIDTH-1:0]        instruction,
  input  logic                                carry_out,
  input  logic                                carry_valid,
  output logic [ALU_OPCODE_WIDTH-1:0]         ALU_opcode,
  output logic [RF_ADDR_WIDTH-1:0]            RF_addr,
  output logic                                RF_we,
  output logic [MEMORY_ADDR_WIDTH-1:0]        MEM_addr,
  output logic                                MEM_we,
  output logic [IMMEDIATE_WIDTH-1:0]          IMM_value,
  output logic [MUX_DEMUX_SELECTOR_WIDTH-1:0] selector,
  output logic                                A_we,
  output logic                                PC_jump_enable,
  output logic [PC_VALUE_WIDTH-1:0]           PC_jump_value,
  output logic                                halted
);

  localparam int unsigned SEL_W = MUX_DEMUX_SELECTOR_WIDTH;
  localparam int unsigned CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);
  localparam logic [SEL_W-1:0] SEL_MEM  = SEL_W'(1);
  localparam logic [SEL_W-1:0] SEL_IMM  = SEL_W'(2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEM_WAIT,
    S_BUBBLE,
    S_HALT
  } state_t;

  state_t                        state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic                          carry_q, carry_d;
  logic [ALU_OPCODE_WIDTH-1:0]   alu_op_q, alu_op_d;
  logic [RF_ADDR_WIDTH-1:0]      rf_addr_q, rf_addr_d;
  logic                          rf_we_q, rf_we_d;
  logic [MEMORY_ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic                          mem_we_q, mem_we_d;
  logic [IMMEDIATE_WIDTH-1:0]    imm_q, imm_d;
  logic [SEL_W-1:0]              sel_q, sel_d;
  logic                          a_we_q, a_we_d;
  logic                          pc_en_q, pc_en_d;
  logic [PC_VALUE_WIDTH-1:0]     pc_val_q, pc_val_d;

  logic [3:0]       op;
  logic [SEL_W-1:0] src;
  logic             accept;
  logic             eff_carry;

  assign op          = instruction[3:0];
  assign src         = instruction[4 +: SEL_W];
  // Ready is gated by rst so fetch sees 0 during reset and 1 right after.
  assign instr_ready = ~rst & (state_q == S_IDLE);
  assign accept      = instr_valid & instr_ready;
  // Same-cycle carry is forwarded ahead of the latched flag.
  assign eff_carry   = carry_valid ? carry_out : carry_q;

  // Next-state and next-output decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    carry_d    = carry_valid ? carry_out : carry_q;
    alu_op_d   = alu_op_q;
    rf_addr_d  = rf_addr_q;
    mem_addr_d = mem_addr_q;
    imm_d      = imm_q;
    sel_d      = sel_q;
    pc_val_d   = pc_val_q;
    rf_we_d    = 1'b0;
    mem_we_d   = 1'b0;
    a_we_d     = 1'b0;
    pc_en_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          // Every accepted instruction clears the fields it does not use.
          alu_op_d   = '1;
          rf_addr_d  = '0;
          mem_addr_d = '0;
          imm_d      = '0;
          sel_d      = '0;
          pc_val_d   = '0;
          case (op)
            4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h8: begin
              sel_d = src;
              if (op != 4'h8) alu_op_d = ALU_OPCODE_WIDTH'(op[2:0]);
              if (src == SEL_MEM) begin
                mem_addr_d = instruction[6 +: MEMORY_ADDR_WIDTH];
                cnt_d      = '0;
                state_d    = S_MEM_WAIT;
              end else begin
                if (src == SEL_IMM) imm_d = instruction[INSTRUCTION_WIDTH-1 -: IMMEDIATE_WIDTH];
                else rf_addr_d = instruction[6 +: RF_ADDR_WIDTH];
                a_we_d = 1'b1;
              end
            end
            4'h9: begin
              rf_addr_d = instruction[4 +: RF_ADDR_WIDTH];
              rf_we_d   = 1'b1;
            end
            4'hA: begin
              mem_addr_d = instruction[4 +: MEMORY_ADDR_WIDTH];
              mem_we_d   = 1'b1;
            end
            4'hB, 4'hC, 4'hD: begin
              // A not-taken conditional jump leaves the cleared NOP fields.
              if ((op == 4'hB) || ((op == 4'hC) && eff_carry) || ((op == 4'hD) && !eff_carry)) begin
                pc_val_d = instruction[4 +: PC_VALUE_WIDTH];
                pc_en_d  = 1'b1;
                state_d  = S_BUBBLE;
              end
            end
            4'hE:    state_d = S_HALT;
            default: ;
          endcase
        end
      end
      S_MEM_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          a_we_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_BUBBLE: state_d = S_IDLE;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      alu_op_q   <= '1;
      rf_addr_q  <= '0;
      rf_we_q    <= 1'b0;
      mem_addr_q <= '0;
      mem_we_q   <= 1'b0;
      imm_q      <= '0;
      sel_q      <= '0;
      a_we_q     <= 1'b0;
      pc_en_q    <= 1'b0;
      pc_val_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      carry_q    <= carry_d;
      alu_op_q   <= alu_op_d;
      rf_addr_q  <= rf_addr_d;
      rf_we_q    <= rf_we_d;
      mem_addr_q <= mem_addr_d;
      mem_we_q   <= mem_we_d;
      imm_q      <= imm_d;
      sel_q      <= sel_d;
      a_we_q     <= a_we_d;
      pc_en_q    <= pc_en_d;
      pc_val_q   <= pc_val_d;
    end
  end

  assign ALU_opcode     = alu_op_q;
  assign RF_addr        = rf_addr_q;
  assign RF_we          = rf_we_q;
  assign MEM_addr       = mem_addr_q;
  assign MEM_we         = mem_we_q;
  assign IMM_value      = imm_q;
  assign selector       = sel_q;
  assign A_we           = a_we_q;
  assign PC_jump_enable = pc_en_q;
  assign PC_jump_value  = pc_val_q;
  assign halted         = (state_q == S_HALT);

endmodule

// File: tb/tb_decode_control_unit.sv
// Directed bench for decode_control_unit (MEM_LATENCY = 2) with an
// expected-output queue checked one cycle after each driven step.
module tb_decode_control_unit;

  typedef struct packed {
    logic       ready;
    logic       halted;
    logic [2:0] alu;
    logic [1:0] rf_addr;
    logic       rf_we;
    logic [9:0] mem_addr;
    logic       mem_we;
    logic [7:0] imm;
    logic [1:0] sel;
    logic       a_we;
    logic       pc_en;
    logic [7:0] pc_val;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instruction;
  logic        carry_out;
  logic        carry_valid;
  logic [2:0]  ALU_opcode;
  logic [1:0]  RF_addr;
  logic        RF_we;
  logic [9:0]  MEM_addr;
  logic        MEM_we;
  logic [7:0]  IMM_value;
  logic [1:0]  selector;
  logic        A_we;
  logic        PC_jump_enable;
  logic [7:0]  PC_jump_value;
  logic        halted;

  int   n_cmp = 0;
  int   n_mis = 0;
  obs_t exp_q[$];

  decode_control_unit #(.MEM_LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instruction(instruction),
    .carry_out(carry_out), .carry_valid(carry_valid),
    .ALU_opcode(ALU_opcode), .RF_addr(RF_addr), .RF_we(RF_we),
    .MEM_addr(MEM_addr), .MEM_we(MEM_we), .IMM_value(IMM_value),
    .selector(selector), .A_we(A_we),
    .PC_jump_enable(PC_jump_enable), .PC_jump_value(PC_jump_value),
    .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(input logic rdy, input logic hlt, input logic [2:0] alu,
                              input logic [1:0] rf, input logic rfwe, input logic [9:0] mem,
                              input logic memwe, input logic [7:0] imm, input logic [1:0] sel,
                              input logic awe, input logic pcen, input logic [7:0] pcv);
    obs_t o;
    o = '{rdy, hlt, alu, rf, rfwe, mem, memwe, imm, sel, awe, pcen, pcv};
    return o;
  endfunction

  function automatic obs_t z(input logic rdy);
    return mk(rdy, 1'b0, 3'h7, 2'h0, 1'b0, 10'h0, 1'b0, 8'h0, 2'h0, 1'b0, 1'b0, 8'h0);
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o = '{instr_ready, halted, ALU_opcode, RF_addr, RF_we, MEM_addr, MEM_we,
          IMM_value, selector, A_we, PC_jump_enable, PC_jump_value};
    return o;
  endfunction

  task automatic check(input string tag);
    obs_t act;
    obs_t e;
    act = sample();
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_mis++;
      $display("FAIL %s: scoreboard empty, observed %h", tag, act);
    end else begin
      e = exp_q.pop_front();
      assert (act === e) else begin
        n_mis++;
        $error("FAIL %s: observed %p expected %p", tag, act, e);
      end
    end
  endtask

  task automatic step(input string tag, input logic v, input logic [15:0] ins,
                      input logic cv, input logic co, input obs_t e);
    instr_valid = v;
    instruction = ins;
    carry_valid = cv;
    carry_out   = co;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instruction = '0; carry_valid = 1'b0; carry_out = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(z(1'b0));
    check("reset_values");
    rst = 1'b0;
    #1;
    exp_q.push_back(z(1'b1));
    check("ready_after_reset");

    step("load_imm",     1, 16'hA528, 0, 0, mk(1,0,3'h7,2'h0,0,10'h000,0,8'hA5,2'h2,1,0,8'h00));
    step("idle_hold",    0, 16'hA528, 0, 0, mk(1,0,3'h7,2'h0,0,10'h000,0,8'hA5,2'h2,0,0,8'h00));
    step("storerf",      1, 16'h0029, 0, 0, mk(1,0,3'h7,2'h2,1,10'h000,0,8'h00,2'h0,0,0,8'h00));
    step("storemem",     1, 16'h3FFA, 0, 0, mk(1,0,3'h7,2'h0,0,10'h3FF,1,8'h00,2'h0,0,0,8'h00));
    step("alu_mem_acc",  1, 16'h5551, 0, 0, mk(0,0,3'h1,2'h0,0,10'h155,0,8'h00,2'h1,0,0,8'h00));
    step("mem_wait",     1, 16'h000F, 0, 0, mk(0,0,3'h1,2'h0,0,10'h155,0,8'h00,2'h1,0,0,8'h00));
    step("mem_done",     1, 16'h000F, 0, 0, mk(1,0,3'h1,2'h0,0,10'h155,0,8'h00,2'h1,1,0,8'h00));
    step("nop_clears",   1, 16'h000F, 0, 0, z(1));
    step("carry_set",    0, 16'h0000, 1, 1, z(1));
    step("jumpc_taken",  1, 16'h03CC, 0, 0, mk(0,0,3'h7,2'h0,0,10'h000,0,8'h00,2'h0,0,1,8'h3C));
    step("bubble",       1, 16'h0029, 0, 0, mk(1,0,3'h7,2'h0,0,10'h000,0,8'h00,2'h0,0,0,8'h3C));
    step("carry_clr",    0, 16'h0000, 1, 0, mk(1,0,3'h7,2'h0,0,10'h000,0,8'h00,2'h0,0,0,8'h3C));
    step("jumpc_nt",     1, 16'h03CC, 0, 0, z(1));
    step("jumpnc_fwd1",  1, 16'h055D, 1, 1, z(1));
    step("jumpnc_fwd0",  1, 16'h055D, 1, 0, mk(0,0,3'h7,2'h0,0,10'h000,0,8'h00,2'h0,0,1,8'h55));
    step("bubble2",      0, 16'h0000, 0, 0, mk(1,0,3'h7,2'h0,0,10'h000,0,8'h00,2'h0,0,0,8'h55));
    step("alu_rf",       1, 16'h00C3, 0, 0, mk(1,0,3'h3,2'h3,0,10'h000,0,8'h00,2'h0,1,0,8'h00));
    step("alu_imm",      1, 16'h7E26, 0, 0, mk(1,0,3'h6,2'h0,0,10'h000,0,8'h7E,2'h2,1,0,8'h00));
    step("jump",         1, 16'h0FFB, 0, 0, mk(0,0,3'h7,2'h0,0,10'h000,0,8'h00,2'h0,0,1,8'hFF));
    step("bubble3",      0, 16'h0000, 1, 1, mk(1,0,3'h7,2'h0,0,10'h000,0,8'h00,2'h0,0,0,8'hFF));
    step("load_mem",     1, 16'hAA98, 0, 0, mk(0,0,3'h7,2'h0,0,10'h2AA,0,8'h00,2'h1,0,0,8'h00));
    rst = 1'b1;
    step("rst_memwait",  0, 16'h0000, 0, 0, z(0));
    rst = 1'b0;
    step("no_awe",       0, 16'h0000, 0, 0, z(1));
    step("flag_reset",   1, 16'h03CC, 0, 0, z(1));
    step("halt",         1, 16'h000E, 0, 0, mk(0,1,3'h7,2'h0,0,10'h000,0,8'h00,2'h0,0,0,8'h00));
    for (int i = 0; i < 20; i++) begin
      step("halt_hold", 1'($urandom_range(0, 1)), ((i % 2) != 0) ? 16'h5551 : 16'h000B,
           1'($urandom_range(0, 1)), 1'b1, mk(0,1,3'h7,2'h0,0,10'h000,0,8'h00,2'h0,0,0,8'h00));
    end
    rst = 1'b1;
    step("rst_halt",     1, 16'h000E, 0, 0, z(0));
    rst = 1'b0;
    instr_valid = 1'b0;
    #1;
    exp_q.push_back(z(1'b1));
    check("ready_after_halt_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
